mem_stage: RTL

- MIPS MEM stage: consumes the EX/MEM pipeline outputs (ALU result, forwarded rt, destination register, control bits, PC+4 and JAL flag).
- Performs byte, halfword and word loads and stores against an internal little-endian data memory.
- Drives the MEM/WB pipeline register.
- Supplies the combinational MEM-stage forwarding value consumed by EX.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_stage_data_memory.sv | 31 +++
 rtl/mem_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcode constants and access-size decode for the MEM stage.
package mem_stage_pkg;

    localparam logic [5:0] OpcodeLb  = 6'h20;
    localparam logic [5:0] OpcodeLh  = 6'h21;
    localparam logic [5:0] OpcodeLw  = 6'h23;
    localparam logic [5:0] OpcodeLbu = 6'h24;
    localparam logic [5:0] OpcodeLhu = 6'h25;
    localparam logic [5:0] OpcodeSb  = 6'h28;
    localparam logic [5:0] OpcodeSh  = 6'h29;
    localparam logic [5:0] OpcodeSw  = 6'h2B;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } access_size_e;

    // Unknown opcodes fall back to a word access.
    function automatic access_size_e decode_size(input logic [5:0] opcode);
        case (opcode)
            OpcodeLb, OpcodeLbu, OpcodeSb: return SizeByte;
            OpcodeLh, OpcodeLhu, OpcodeSh: return SizeHalf;
            default:                       return SizeWord;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [5:0] opcode);
        return (opcode == OpcodeLb) || (opcode == OpcodeLh);
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory: byte-enabled synchronous write, two combinational read ports.
module mem_stage_data_memory #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata    = mem[addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: sized loads/stores against data memory, forwarding value and MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_write_data,
    input  logic [5:0]        i_opcode,
    input  logic [4:0]        i_write_register,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_to_reg,
    input  logic              i_is_jal,
    input  logic [31:0]       i_pc_plus_4,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data,
    output logic [31:0]       o_fwd_result,
    output logic [31:0]       o_read_data,
    output logic [31:0]       o_alu_result,
    output logic [4:0]        o_write_register,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic              o_misaligned
);

    access_size_e      size;
    logic [1:0]        lane;
    logic              misaligned;
    logic              mem_we;
    logic [3:0]        byte_en;
    logic [31:0]       store_data;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [ADDR_W-1:0] word_index;

    assign size       = decode_size(i_opcode);
    assign lane       = i_alu_result[1:0];
    assign word_index = i_alu_result[ADDR_W+1:2];

    always_comb begin
        misaligned = 1'b0;
        if (i_mem_read || i_mem_write) begin
            case (size)
                SizeHalf: misaligned = lane[0];
                SizeWord: misaligned = (lane != 2'b00);
                default:  misaligned = 1'b0;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en    = 4'b1111;
        store_data = i_write_data;
        case (size)
            SizeByte: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{i_write_data[7:0]}};
            end
            SizeHalf: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{i_write_data[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = i_write_data;
            end
        endcase
    end

    assign mem_we = i_mem_write && !i_stall && !i_flush && reset && !misaligned;

    mem_stage_data_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_data_memory (
        .clk      (clk),
        .we       (mem_we),
        .addr     (word_index),
        .be       (byte_en),
        .wdata    (store_data),
        .rdata    (rd_word),
        .dbg_addr (i_dbg_addr),
        .dbg_data (o_dbg_data)
    );

    always_comb begin
        byte_sel  = rd_word[8*lane +: 8];
        half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (size)
            SizeByte: load_data = is_signed_load(i_opcode) ? {{24{byte_sel[7]}}, byte_sel}
                                                           : {24'b0, byte_sel};
            SizeHalf: load_data = is_signed_load(i_opcode) ? {{16{half_sel[15]}}, half_sel}
                                                           : {16'b0, half_sel};
            default:  load_data = rd_word;
        endcase
    end

    assign o_fwd_result = i_is_jal ? i_pc_plus_4 : i_alu_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_read_data      <= '0;
            o_alu_result     <= '0;
            o_write_register <= '0;
            o_reg_write      <= 1'b0;
            o_mem_to_reg     <= 1'b0;
            o_misaligned     <= 1'b0;
        end else if (i_stall) begin
            o_read_data      <= o_read_data;
            o_alu_result     <= o_alu_result;
            o_write_register <= o_write_register;
            o_reg_write      <= o_reg_write;
            o_mem_to_reg     <= o_mem_to_reg;
            o_misaligned     <= o_misaligned;
        end else if (i_flush) begin
            o_read_data      <= '0;
            o_alu_result     <= '0;
            o_write_register <= '0;
            o_reg_write      <= 1'b0;
            o_mem_to_reg     <= 1'b0;
            o_misaligned     <= 1'b0;
        end else begin
            o_read_data      <= i_mem_read ? load_data : 32'h0;
            o_alu_result     <= o_fwd_result;
            o_write_register <= i_write_register;
            o_reg_write      <= i_reg_write && !misaligned;
            o_mem_to_reg     <= i_mem_to_reg;
            o_misaligned     <= misaligned;
        end
    end

endmodule
